// File: rtl/ppa_pkg.sv
// ppa_pkg: shared types and elaboration-time helpers for pp_accumulator.
//   ppa_state_e : accumulator FSM states (IDLE / ACCUM / DONE)
//   acc_width   : exact-sum accumulator width for a given partial-product shape
//   cnt_width   : beat counter width
//   sat_max/min : signed saturation limits for a given result width
package ppa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } ppa_state_e;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned npp);
    return dw + npp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned npp);
    return (npp <= 2) ? 1 : $clog2(npp);
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/ppa_range_check.sv
// ppa_range_check: reduces the exact accumulator sum to the OUT_WIDTH result.
//   sum      in  ACC_WIDTH  exact signed sum
//   result   out OUT_WIDTH  wrapped low bits, or saturated value when
//                           PPA_SATURATE_EN is defined and the sum is out of range
//   overflow out 1          sum not representable in OUT_WIDTH bits signed
module ppa_range_check
  import ppa_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [OUT_WIDTH-1:0] result,
  output logic                        overflow
);

  if (OUT_WIDTH < ACC_WIDTH) begin : g_narrow
    // Representable iff the bits from the result sign bit upward are all equal.
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    assign upper    = sum[ACC_WIDTH-1:OUT_WIDTH-1];
    assign overflow = !((&upper) || !(|upper));
`ifdef PPA_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));
    assign result = overflow ? (sum[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX)
                             : sum[OUT_WIDTH-1:0];
`else
    assign result = sum[OUT_WIDTH-1:0];
`endif
  end else begin : g_full
    assign overflow = 1'b0;
    assign result   = sum[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/pp_accumulator.sv
// pp_accumulator: sequential partial-product accumulator, result = sum pp_i * 2^i
// over NUM_PP accepted beats (last beat negatively weighted when SIGNED_LAST=1).
// Optional feature macro: PPA_SATURATE_EN (saturate result on overflow).
//   clk, reset          clock / asynchronous active-high reset
//   clear               synchronous abort of the product in flight
//   pp_data, pp_valid,  partial-product input stream (valid/ready)
//   pp_ready
//   result, overflow,   accumulated product output (valid/ready)
//   result_valid,
//   result_ready
//   busy                high while accumulating or holding a result
module pp_accumulator
  import ppa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_PP      = 16,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter bit          SIGNED_LAST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] pp_data,
  input  logic                         pp_valid,
  output logic                         pp_ready,
  output logic signed [OUT_WIDTH-1:0]  result,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         overflow,
  output logic                         busy
);

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, NUM_PP);
  localparam int unsigned CNT_W     = cnt_width(NUM_PP);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PP - 1);

  ppa_state_e                  state, state_nx;
  logic signed [ACC_WIDTH-1:0] acc, acc_nx, term;
  logic        [CNT_W-1:0]     cnt, cnt_nx;
  logic                        accept;
  logic        [OUT_WIDTH-1:0] rc_result;
  logic                        rc_overflow;

  assign pp_ready = !reset && !clear && ((state != ST_DONE) || result_ready);
  assign accept   = pp_valid && pp_ready;

  // cnt is 0 in IDLE and DONE, so the handoff beat is weighted as beat 0.
  always_comb begin
    term = ACC_WIDTH'(pp_data) <<< cnt;
    if (SIGNED_LAST && (cnt == LAST_IDX)) term = -term;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    if (clear) begin
      state_nx = ST_IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nx = ST_ACCUM;
            acc_nx   = term;
            cnt_nx   = cnt + 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_nx = acc + term;
            if (cnt == LAST_IDX) begin
              state_nx = ST_DONE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            if (accept) begin
              state_nx = ST_ACCUM;
              acc_nx   = term;
              cnt_nx   = cnt + 1'b1;
            end else begin
              state_nx = ST_IDLE;
              acc_nx   = '0;
              cnt_nx   = '0;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          acc_nx   = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  ppa_range_check #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_range_check (
    .sum      (acc),
    .result   (rc_result),
    .overflow (rc_overflow)
  );

  assign result_valid = (state == ST_DONE);
  assign result       = result_valid ? rc_result : '0;
  assign overflow     = result_valid && rc_overflow;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_pp_accumulator.sv
module tb_pp_accumulator;

  typedef int beats_t[8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clear, pp_valid, result_ready;
  logic signed [7:0] pp_data;

  logic              a_pp_ready, a_result_valid, a_overflow, a_busy;
  logic signed [15:0] a_result;
  logic              b_pp_ready, b_result_valid, b_overflow, b_busy;
  logic signed [15:0] b_result;
  logic              c_pp_ready, c_result_valid, c_overflow, c_busy;
  logic signed [11:0] c_result;

  int checks   = 0;
  int failures = 0;

`ifdef PPA_SATURATE_EN
  localparam logic signed [11:0] C_OVF_EXP = 12'sd2047;
`else
  localparam logic signed [11:0] C_OVF_EXP = -12'sd383;
`endif

  pp_accumulator #(.DATA_WIDTH(8), .NUM_PP(8), .OUT_WIDTH(16), .SIGNED_LAST(1'b0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .pp_data(pp_data), .pp_valid(pp_valid),
    .pp_ready(a_pp_ready), .result(a_result), .result_valid(a_result_valid),
    .result_ready(result_ready), .overflow(a_overflow), .busy(a_busy));

  pp_accumulator #(.DATA_WIDTH(8), .NUM_PP(8), .OUT_WIDTH(16), .SIGNED_LAST(1'b1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .pp_data(pp_data), .pp_valid(pp_valid),
    .pp_ready(b_pp_ready), .result(b_result), .result_valid(b_result_valid),
    .result_ready(result_ready), .overflow(b_overflow), .busy(b_busy));

  pp_accumulator #(.DATA_WIDTH(8), .NUM_PP(8), .OUT_WIDTH(12), .SIGNED_LAST(1'b0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .pp_data(pp_data), .pp_valid(pp_valid),
    .pp_ready(c_pp_ready), .result(c_result), .result_valid(c_result_valid),
    .result_ready(result_ready), .overflow(c_overflow), .busy(c_busy));

  // One beat presented for exactly one clock edge; returns at edge + 1.
  task automatic feed(input int v);
    pp_data  = 8'(v);
    pp_valid = 1'b1;
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_data  = '0;
  endtask

  task automatic feed_product(input beats_t b);
    for (int i = 0; i < 8; i++) feed(b[i]);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; pp_valid = 1'b0; pp_data = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_pp_ready !== 1'b0) begin failures++; $display("FAIL reset_pp_ready got=%b exp=0", a_pp_ready); end
    checks++; if (a_result !== 16'sd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", a_result); end
    checks++; if (a_result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid got=%b exp=0", a_result_valid); end
    checks++; if (a_overflow !== 1'b0 || b_overflow !== 1'b0 || c_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b%b%b exp=000", a_overflow, b_overflow, c_overflow); end
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b%b exp=000", a_busy, b_busy, c_busy); end
    checks++; if (b_result_valid !== 1'b0 || c_result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_bc got=%b%b exp=00", b_result_valid, c_result_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (a_pp_ready !== 1'b1 || b_pp_ready !== 1'b1 || c_pp_ready !== 1'b1) begin failures++; $display("FAIL release_pp_ready got=%b%b%b exp=111", a_pp_ready, b_pp_ready, c_pp_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    beats_t v;
    v = '{3, 0, 3, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) feed(v[i]);
    checks++; if (a_result_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", a_result_valid); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", a_busy); end
    feed(v[7]);
    checks++; if (a_result_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", a_result_valid); end
    checks++; if (a_result !== 16'sd15) begin failures++; $display("FAIL basic_result got=%0d exp=15", a_result); end
    checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b exp=0", a_overflow); end
    checks++; if (b_result !== 16'sd15) begin failures++; $display("FAIL basic_signed_inst got=%0d exp=15", b_result); end
    checks++; if (c_result !== 12'sd15) begin failures++; $display("FAIL basic_narrow_inst got=%0d exp=15", c_result); end
    handshake();
    checks++; if (a_result_valid !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL basic_release got=%b%b exp=00", a_result_valid, a_busy); end
  endtask

  task automatic test_signed_last();
    beats_t v;
    v = '{0, -3, -3, -3, -3, -3, -3, -3};
    feed_product(v);
    checks++; if (b_result !== 16'sd6) begin failures++; $display("FAIL signed_last_result got=%0d exp=6", b_result); end
    checks++; if (a_result !== -16'sd762) begin failures++; $display("FAIL unsigned_last_result got=%0d exp=-762", a_result); end
    checks++; if (c_result !== -12'sd762 || c_overflow !== 1'b0) begin failures++; $display("FAIL narrow_neg got=%0d ovf=%b exp=-762 ovf=0", c_result, c_overflow); end
    handshake();
  endtask

  task automatic test_overflow();
    beats_t v;
    v = '{127, 127, 127, 127, 127, 127, 127, 127};
    feed_product(v);
    checks++; if (c_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", c_overflow); end
    checks++; if (c_result !== C_OVF_EXP) begin failures++; $display("FAIL ovf_result got=%0d exp=%0d", c_result, C_OVF_EXP); end
    checks++; if (a_result !== 16'sd32385 || a_overflow !== 1'b0) begin failures++; $display("FAIL full_width got=%0d ovf=%b exp=32385 ovf=0", a_result, a_overflow); end
    checks++; if (b_result !== -16'sd127) begin failures++; $display("FAIL signed_127 got=%0d exp=-127", b_result); end
    handshake();
    checks++; if (c_overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", c_overflow); end
  endtask

  task automatic test_back_to_back();
    beats_t v;
    v = '{1, 0, 0, 0, 0, 0, 0, 0};
    feed_product(v);
    for (int i = 0; i < 5; i++) begin
      pp_valid = 1'b1; pp_data = 8'sd2; result_ready = 1'b0;
      #1;
      checks++; if (a_pp_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready cyc=%0d got=%b exp=0", i, a_pp_ready); end
      checks++; if (a_result !== 16'sd1 || a_result_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_hold cyc=%0d got=%0d v=%b exp=1 v=1", i, a_result, a_result_valid); end
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    #1;
    checks++; if (a_pp_ready !== 1'b1) begin failures++; $display("FAIL b2b_handoff_ready got=%b exp=1", a_pp_ready); end
    @(posedge clk);
    #1;
    result_ready = 1'b0; pp_valid = 1'b0; pp_data = '0;
    checks++; if (a_busy !== 1'b1 || a_result_valid !== 1'b0) begin failures++; $display("FAIL b2b_handoff_state busy=%b v=%b exp busy=1 v=0", a_busy, a_result_valid); end
    feed(1);
    for (int i = 0; i < 6; i++) feed(0);
    checks++; if (a_result_valid !== 1'b1 || a_result !== 16'sd4) begin failures++; $display("FAIL b2b_second got=%0d v=%b exp=4 v=1", a_result, a_result_valid); end
    handshake();
  endtask

  task automatic test_clear();
    beats_t v;
    for (int i = 0; i < 4; i++) feed(5);
    clear = 1'b1; pp_valid = 1'b1; pp_data = 8'sd9;
    #1;
    checks++; if (a_pp_ready !== 1'b0) begin failures++; $display("FAIL clear_pp_ready got=%b exp=0", a_pp_ready); end
    @(posedge clk);
    #1;
    clear = 1'b0; pp_valid = 1'b0; pp_data = '0;
    checks++; if (a_busy !== 1'b0 || a_result_valid !== 1'b0) begin failures++; $display("FAIL clear_idle busy=%b v=%b exp=00", a_busy, a_result_valid); end
    v = '{1, 1, 0, 0, 0, 0, 0, 0};
    feed_product(v);
    checks++; if (a_result !== 16'sd3 || a_result_valid !== 1'b1) begin failures++; $display("FAIL clear_next got=%0d v=%b exp=3 v=1", a_result, a_result_valid); end
    handshake();
  endtask

  task automatic test_reset_mid();
    beats_t v;
    for (int i = 0; i < 5; i++) feed(3);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0 || a_result_valid !== 1'b0 || a_overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_outs busy=%b v=%b ovf=%b exp=000", a_busy, a_result_valid, a_overflow); end
    checks++; if (a_pp_ready !== 1'b0 || a_result !== 16'sd0) begin failures++; $display("FAIL rst_mid_ready_res rdy=%b res=%0d exp rdy=0 res=0", a_pp_ready, a_result); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    v = '{3, 0, 3, 0, 0, 0, 0, 0};
    feed_product(v);
    checks++; if (a_result !== 16'sd15 || a_result_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_after got=%0d v=%b exp=15 v=1", a_result, a_result_valid); end
    handshake();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed_last();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_accumulator.md
# pp_accumulator

Parametrised sequential partial-product accumulator for the shift-add multiplier datapath. Accepts a stream of `NUM_PP` signed partial products per product, one per accepted beat, and forms Σ pp_i·2^i. The sum optionally treats the final term as the negatively weighted multiplier-MSB term for two's-complement multipliers. It presents the sum on a valid/ready output with a range-overflow flag, and sits between the partial-product generator and the result FIFO/writeback stage.

## Interface
- `DATA_WIDTH`, 16: signed partial-product width.
- `NUM_PP`, 16: partial products per result (≥2).
- `OUT_WIDTH`, 32: result width. Legal range is 2 to `DATA_WIDTH+NUM_PP`.
- `SIGNED_LAST`, 1: when 1, the last beat is subtracted (weight −2^(NUM_PP−1)). When 0, it is added.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `clear`  in  1  synchronous abort; discards the product in flight.
- `pp_data`  in  DATA_WIDTH  signed partial product, beat i has weight 2^i.
- `pp_valid`  in  1  `pp_data` valid.
- `pp_ready`  out  1  accumulator can take a beat.
- `result`  out  OUT_WIDTH  signed accumulated product.
- `result_valid`  out  1  `result`/`overflow` valid.
- `result_ready`  in  1  consumer takes result.
- `overflow`  out  1  exact sum not representable in `OUT_WIDTH` bits signed.
- `busy`  out  1  high in ACCUM or DONE.

## Operation
- Internal accumulator width is `DATA_WIDTH+NUM_PP`. At this width the exact sum never overflows internally.
- The implementation method is free (right-shift or left-aligned add), but the result must equal the exact Σ.
- The beat counter runs 0..NUM_PP−1. Beat index = number of beats already accepted for the current product.
- States:
  - IDLE: accumulator zero, count 0.
  - ACCUM: at least one beat accepted.
  - DONE: result held.
- State transitions:
  - IDLE→ACCUM on first accept.
  - IDLE/ACCUM→DONE on the NUM_PP-th accept. For NUM_PP beats, IDLE→ACCUM is skipped only if the first beat is also the last, which is impossible since NUM_PP≥2.
  - DONE→IDLE on `result_valid && result_ready` without a simultaneous accept.
  - DONE→ACCUM on `result_valid && result_ready` with a simultaneous accept.
- `pp_ready` = (state≠DONE) || `result_ready`. This is combinational from `result_ready`. In the handoff cycle, the accepted beat is beat 0 of the next product.
- `overflow` is computed from the exact sum in DONE: 1 if the upper `DATA_WIDTH+NUM_PP−OUT_WIDTH+1` bits are not all equal. It is constant 0 when `OUT_WIDTH = DATA_WIDTH+NUM_PP`.
- Without saturation, `result` = low `OUT_WIDTH` bits of the sum (wrap).
- `clear`:
  - Priority over everything except `reset`.
  - Next cycle: IDLE, accumulator 0, count 0, `result_valid`=0, `overflow`=0.
  - A beat presented with `clear` is not accepted; `pp_ready` is forced 0 while `clear`=1.

## Timing
- Reset values:
  - `result`=0, `result_valid`=0, `overflow`=0, `busy`=0.
  - `pp_ready`=1 after reset deassertion; 0 while `reset` is high.
  - State IDLE, count 0.
- Latency: `result_valid` rises the cycle after the NUM_PP-th accepted beat. Minimum product period is NUM_PP cycles, with no bubble between products.
- `result` and `overflow` stay stable while `result_valid && !result_ready`.
- Gaps (`pp_valid`=0) in ACCUM hold all state. There is no timeout.
- Reset mid-product: the partial sum is discarded asynchronously. No result is produced for that product.

## Configuration
- `PPA_SATURATE_EN` defined: on overflow, `result` = +2^(OUT_WIDTH−1)−1 if the exact sum is positive, else −2^(OUT_WIDTH−1). `overflow` is still asserted.
- `PPA_SATURATE_EN` undefined: `result` wraps (low bits). No saturation logic is synthesised.

## Structure
- `ppa_pkg` holds:
  - state enum (IDLE/ACCUM/DONE)
  - `ACC_WIDTH` computation function
  - `clog2`-based counter-width function
  - saturation max/min constant functions
- One sub-module, `ppa_range_check`: takes the exact sum and produces `overflow` plus the wrapped or saturated `result` (saturation under `PPA_SATURATE_EN`).
- The FSM, counter and adder stay in the top-level module.

## Test plan
- D=8, N=8, OUT=16, SIGNED_LAST=0: beats 3,0,3,0,0,0,0,0 → `result`=15, `overflow`=0, `result_valid` one cycle after beat 8.
- D=8, N=8, SIGNED_LAST=1: beats 0,−3,−3,−3,−3,−3,−3,−3 (−3 × −2) → `result`=6.
- D=8, N=8, OUT=12: eight beats of 127 (sum 32385):
  - without macro → `overflow`=1, `result`=−383;
  - with `PPA_SATURATE_EN` → `result`=2047.
- Back-to-back products with `result_ready` low 5 cycles in DONE:
  - `pp_ready`=0 and `result` stable throughout;
  - on handshake, beat 0 of the next product is accepted in the same cycle;
  - the second result is correct.
- `clear` after beat 4, then a full new product 1,1,0,0,0,0,0,0 → `result`=3, with no stale contribution.
- `reset` asserted after beat 5 → all outputs 0 immediately. After release, a full product yields the correct sum.
